// File: rtl/simmem_delay_bank.sv
// Purpose: per-slot release-delay countdown for a simulated memory controller's message bank.
// Latency: release_en_o[a] rises in the cycle after edge t+D for an entry accepted at edge t with delay D.
// Backpressure: in_ready_o drops while the addressed slot is occupied, unless that slot is being released this cycle.
//
// Ports:
//   clk_i, rst_i            clock; asynchronous active-high reset
//   in_valid_i/in_ready_o   new delay entry handshake (in_addr_i = slot, in_delay_i = cycles)
//   release_en_o            multi-hot; slot may be released by the message bank
//   released_addr_onehot_i  slot actually released by the message bank this cycle (onehot or zero)
//   err_o                   sticky protocol-error flag (illegal or multi-hot release)
// Optional feature (macro SIMMEM_DELAY_BANK_STATS_EN):
//   occupancy_o             registered count of valid slots
//   max_occupancy_o         high-water mark of occupancy_o
module simmem_delay_bank #(
  parameter int NumSlots   = 8,
  parameter int AddrWidth  = 3,
  parameter int DelayWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AddrWidth-1:0]  in_addr_i,
  input  logic [DelayWidth-1:0] in_delay_i,
  output logic [NumSlots-1:0]   release_en_o,
  input  logic [NumSlots-1:0]   released_addr_onehot_i,
  output logic                  err_o
`ifdef SIMMEM_DELAY_BANK_STATS_EN
  ,
  output logic [$clog2(NumSlots+1)-1:0] occupancy_o,
  output logic [$clog2(NumSlots+1)-1:0] max_occupancy_o
`endif
);

  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [DelayWidth-1:0] cnt_q [NumSlots];
  logic [DelayWidth-1:0] cnt_d [NumSlots];
  logic                  err_q;
  logic                  fire;
  logic [NumSlots-1:0]   legal_rel;
  logic                  bad_rel;

  // Decoded purely from state so the message bank sees no input-to-output path.
  always_comb begin
    release_en_o = '0;
    for (int a = 0; a < NumSlots; a++) begin
      release_en_o[a] = valid_q[a] && (cnt_q[a] == '0);
    end
  end

  // A slot being released this cycle is treated as free, allowing same-cycle re-arm.
  assign in_ready_o = !valid_q[in_addr_i] || released_addr_onehot_i[in_addr_i];
  assign fire       = in_valid_i && in_ready_o;

  // Only releases of enabled slots take effect; anything else is flagged.
  assign legal_rel = released_addr_onehot_i & release_en_o;
  assign bad_rel   = ((released_addr_onehot_i & ~release_en_o) != '0) ||
                     ((released_addr_onehot_i &
                       (released_addr_onehot_i - NumSlots'(1))) != '0);

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int a = 0; a < NumSlots; a++) begin
      if (fire && (in_addr_i == AddrWidth'(a))) begin
        // New load wins over a release of the same slot.
        valid_d[a] = 1'b1;
        cnt_d[a]   = in_delay_i;
      end else begin
        if (legal_rel[a]) begin
          valid_d[a] = 1'b0;
        end
        // Saturating countdown: parked at zero until released.
        if (valid_q[a] && (cnt_q[a] != '0)) begin
          cnt_d[a] = cnt_q[a] - DelayWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int a = 0; a < NumSlots; a++) begin
        cnt_q[a] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (bad_rel) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

`ifdef SIMMEM_DELAY_BANK_STATS_EN
  localparam int OccWidth = $clog2(NumSlots + 1);

  logic [OccWidth-1:0] occ_d;
  logic [OccWidth-1:0] occ_q;
  logic [OccWidth-1:0] max_q;

  // Counting next-state valid bits gives +1 per fresh fire, -1 per legal
  // release, and net zero when both hit the same slot.
  always_comb begin
    occ_d = '0;
    for (int a = 0; a < NumSlots; a++) begin
      occ_d = occ_d + OccWidth'(valid_d[a]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
      max_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (occ_d > max_q) begin
        max_q <= occ_d;
      end
    end
  end

  assign occupancy_o     = occ_q;
  assign max_occupancy_o = max_q;
`endif

endmodule

// File: tb/tb_simmem_delay_bank.sv
module tb_simmem_delay_bank;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [2:0] in_addr_i = '0;
  logic [7:0] in_delay_i = '0;
  logic [7:0] release_en_o;
  logic [7:0] released_addr_onehot_i = '0;
  logic       err_o;
`ifdef SIMMEM_DELAY_BANK_STATS_EN
  logic [3:0] occupancy_o;
  logic [3:0] max_occupancy_o;
`endif

  int checks = 0;
  int errors = 0;

  simmem_delay_bank #(.NumSlots(8), .AddrWidth(3), .DelayWidth(8)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .in_valid_i             (in_valid_i),
    .in_ready_o             (in_ready_o),
    .in_addr_i              (in_addr_i),
    .in_delay_i             (in_delay_i),
    .release_en_o           (release_en_o),
    .released_addr_onehot_i (released_addr_onehot_i),
    .err_o                  (err_o)
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    ,
    .occupancy_o            (occupancy_o),
    .max_occupancy_o        (max_occupancy_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    released_addr_onehot_i = '0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL reset_release_en got %h want 00", release_en_o);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", err_o);
    end
  endtask

  task automatic test_basic_delay();
    in_valid_i = 1'b1; in_addr_i = 3'd2; in_delay_i = 8'd3;
    tick();                       // acceptance edge t
    in_valid_i = 1'b0;
    ticks(2);                     // after edge t+2: still counting
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL basic_early got %h want 00", release_en_o);
    end
    tick();                       // after edge t+3
    checks++;
    if (release_en_o !== 8'h04) begin
      errors++; $display("FAIL basic_rise got %h want 04", release_en_o);
    end
    tick();
    checks++;
    if (release_en_o !== 8'h04) begin
      errors++; $display("FAIL basic_hold got %h want 04", release_en_o);
    end
    released_addr_onehot_i = 8'h04;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL basic_released got %h want 00", release_en_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL basic_err got %b want 0", err_o);
    end
  endtask

  task automatic test_zero_delay();
    in_valid_i = 1'b1; in_addr_i = 3'd5; in_delay_i = 8'd0;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (release_en_o !== 8'h20) begin
      errors++; $display("FAIL zero_delay got %h want 20", release_en_o);
    end
    released_addr_onehot_i = 8'h20;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL zero_delay_clear got %h want 00", release_en_o);
    end
  endtask

  task automatic test_back_to_back();
    in_valid_i = 1'b1; in_addr_i = 3'd1; in_delay_i = 8'd4;
    tick();                       // edge t
    in_addr_i = 3'd6; in_delay_i = 8'd3;
    tick();                       // edge t+1
    in_valid_i = 1'b0;
    ticks(2);                     // after edge t+3
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL b2b_early got %h want 00", release_en_o);
    end
    tick();                       // after edge t+4: both zero together
    checks++;
    if (release_en_o !== 8'h42) begin
      errors++; $display("FAIL b2b_both got %h want 42", release_en_o);
    end
    released_addr_onehot_i = 8'h02;
    tick();
    checks++;
    if (release_en_o !== 8'h40) begin
      errors++; $display("FAIL b2b_first got %h want 40", release_en_o);
    end
    released_addr_onehot_i = 8'h40;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL b2b_second got %h want 00", release_en_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL b2b_err got %b want 0", err_o);
    end
  endtask

  task automatic test_rearm();
    int early_hits;
    in_valid_i = 1'b1; in_addr_i = 3'd3; in_delay_i = 8'd0;
    tick();
    checks++;
    if (release_en_o !== 8'h08) begin
      errors++; $display("FAIL rearm_armed got %h want 08", release_en_o);
    end
    in_delay_i = 8'd10;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++; $display("FAIL rearm_blocked got %b want 0", in_ready_o);
    end
    released_addr_onehot_i = 8'h08;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++; $display("FAIL rearm_ready got %b want 1", in_ready_o);
    end
    tick();                       // edge t: release + reload
    in_valid_i = 1'b0;
    released_addr_onehot_i = 8'h00;
    early_hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (release_en_o[3] !== 1'b0) early_hits++;
      if (i < 9) tick();
    end
    checks++;
    if (early_hits !== 0) begin
      errors++; $display("FAIL rearm_quiet got %0d early cycles want 0", early_hits);
    end
    tick();                       // after edge t+10
    checks++;
    if (release_en_o !== 8'h08) begin
      errors++; $display("FAIL rearm_rise got %h want 08", release_en_o);
    end
    released_addr_onehot_i = 8'h08;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL rearm_err got %b want 0", err_o);
    end
  endtask

  task automatic test_error();
    in_valid_i = 1'b1; in_addr_i = 3'd4; in_delay_i = 8'd8;
    tick();                       // edge t, cnt=8
    in_valid_i = 1'b0;
    ticks(3);                     // cnt=5
    released_addr_onehot_i = 8'h10;
    tick();                       // illegal release at edge t+4
    released_addr_onehot_i = 8'h00;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_illegal got %b want 1", err_o);
    end
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL err_no_release got %h want 00", release_en_o);
    end
    ticks(3);                     // after edge t+7
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL err_sched_early got %h want 00", release_en_o);
    end
    tick();                       // after edge t+8
    checks++;
    if (release_en_o !== 8'h10) begin
      errors++; $display("FAIL err_sched got %h want 10", release_en_o);
    end
    released_addr_onehot_i = 8'h10;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b want 1", err_o);
    end
    // Multi-hot release: enabled bits still clear.
    in_valid_i = 1'b1; in_addr_i = 3'd0; in_delay_i = 8'd0;
    tick();
    in_addr_i = 3'd5;
    tick();
    in_valid_i = 1'b0;
    released_addr_onehot_i = 8'h21;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL multi_clear got %h want 00", release_en_o);
    end
    do_reset();
    released_addr_onehot_i = 8'h21;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL multi_err got %b want 1", err_o);
    end
  endtask

  task automatic test_reset_mid();
    in_valid_i = 1'b1; in_addr_i = 3'd7; in_delay_i = 8'd0;
    tick();
    in_addr_i = 3'd0; in_delay_i = 8'd40;
    tick();
    in_valid_i = 1'b0;
    ticks(2);
    checks++;
    if (release_en_o !== 8'h80) begin
      errors++; $display("FAIL mid_pre got %h want 80", release_en_o);
    end
    #2;
    rst_i = 1'b1;                 // away from any clock edge
    #1;
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL mid_rst_release got %h want 00", release_en_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_err got %b want 0", err_o);
    end
    tick();
    rst_i = 1'b0;
    ticks(45);
    checks++;
    if (release_en_o !== 8'h00) begin
      errors++; $display("FAIL mid_discard got %h want 00", release_en_o);
    end
  endtask

`ifdef SIMMEM_DELAY_BANK_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      in_valid_i = 1'b1; in_addr_i = 3'(a); in_delay_i = 8'd20;
      tick();
    end
    in_valid_i = 1'b0;
    checks++;
    if (occupancy_o !== 4'd8) begin
      errors++; $display("FAIL stats_occ_full got %0d want 8", occupancy_o);
    end
    checks++;
    if (max_occupancy_o !== 4'd8) begin
      errors++; $display("FAIL stats_max_full got %0d want 8", max_occupancy_o);
    end
    in_addr_i = 3'd0; #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++; $display("FAIL stats_ready0 got %b want 0", in_ready_o);
    end
    in_addr_i = 3'd7; #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++; $display("FAIL stats_ready7 got %b want 0", in_ready_o);
    end
    ticks(21);
    released_addr_onehot_i = 8'h01;
    tick();
    released_addr_onehot_i = 8'h02;
    tick();
    released_addr_onehot_i = 8'h00;
    checks++;
    if (occupancy_o !== 4'd6) begin
      errors++; $display("FAIL stats_occ_after got %0d want 6", occupancy_o);
    end
    checks++;
    if (max_occupancy_o !== 4'd8) begin
      errors++; $display("FAIL stats_max_after got %0d want 8", max_occupancy_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_delay();
    test_zero_delay();
    test_back_to_back();
    test_rearm();
    test_error();
    test_reset_mid();
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
